// File: rtl/ss_pkg.sv
// Shared ss stream package: keep-width helpers and the default-width beat struct.
package ss_pkg;

  localparam int SS_DATA_W = 32;
  localparam int SS_USER_W = 1;

  function automatic int keep_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int out_keep_w(input int data_w, input int ratio);
    return (data_w / 8) * ratio;
  endfunction

  typedef struct packed {
    logic [SS_DATA_W-1:0]   data;
    logic [SS_DATA_W/8-1:0] keep;
    logic                   last;
    logic [SS_USER_W-1:0]   user;
  } ss_beat_t;

endpackage

// File: rtl/ss_upsizer_if.sv
// Single-clock ss stream bundle; master drives payload/valid, slave drives ready.
interface ss_upsizer_if import ss_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int USER_W = 1
);

  localparam int KEEP_W = keep_w(DATA_W);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [KEEP_W-1:0] keep;
  logic              last;
  logic [USER_W-1:0] user;

  modport master (output valid, data, keep, last, user, input ready);
  modport slave  (input valid, data, keep, last, user, output ready);

endinterface

// File: rtl/ss_upsizer_acc.sv
// Lane accumulator for ss_upsizer: holds the first RATIO-1 narrow beats of a word
// plus the word's captured user, and the beat counter.
module ss_upsizer_acc import ss_pkg::*; #(
  parameter int  IN_DATA_W  = 32,
  parameter int  RATIO      = 4,
  parameter int  USER_W     = 1,
  localparam int CNT_W      = $clog2(RATIO),
  localparam int IN_KEEP_W  = keep_w(IN_DATA_W),
  localparam int ACC_DATA_W = IN_DATA_W * (RATIO - 1),
  localparam int ACC_KEEP_W = IN_KEEP_W * (RATIO - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  clr,
  input  logic [IN_DATA_W-1:0]  wr_data,
  input  logic [IN_KEEP_W-1:0]  wr_keep,
  input  logic [USER_W-1:0]     wr_user,
  output logic [CNT_W-1:0]      cnt,
  output logic [ACC_DATA_W-1:0] acc_data,
  output logic [ACC_KEEP_W-1:0] acc_keep,
  output logic [USER_W-1:0]     acc_user
);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the lane storage is a handful of flops, not a RAM, so resetting it is
  // cheap and guarantees a mid-packet reset leaves no stale bytes behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      acc_data <= '0;
      acc_keep <= '0;
      acc_user <= '0;
    end else if (clr) begin
      cnt      <= '0;
      acc_keep <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < RATIO - 1; k++) begin
        if (cnt == CNT_W'(k)) begin
          acc_data[k*IN_DATA_W +: IN_DATA_W] <= wr_data;
          acc_keep[k*IN_KEEP_W +: IN_KEEP_W] <= wr_keep;
        end
      end
      if (cnt == '0) acc_user <= wr_user;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ss_upsizer.sv
// ss stream width upsizer: packs RATIO narrow beats into one wide beat, flushing early on last.
// Optional sticky keep-protocol checker on port err, enabled by defining SS_UPSIZER_ERR_EN.
module ss_upsizer import ss_pkg::*; #(
  parameter int IN_DATA_W = 32,
  parameter int RATIO     = 4,
  parameter int USER_W    = 1
) (
  input  logic         clk,
  input  logic         rst,
  ss_upsizer_if.slave  in_ss,
  ss_upsizer_if.master out_ss
`ifdef SS_UPSIZER_ERR_EN
  ,
  output logic         err
`endif
);

  localparam int CNT_W      = $clog2(RATIO);
  localparam int IN_KEEP_W  = keep_w(IN_DATA_W);
  localparam int OUT_DATA_W = IN_DATA_W * RATIO;
  localparam int OUT_KEEP_W = out_keep_w(IN_DATA_W, RATIO);

  logic [CNT_W-1:0]                   cnt;
  logic [IN_DATA_W*(RATIO-1)-1:0]     acc_data;
  logic [IN_KEEP_W*(RATIO-1)-1:0]     acc_keep;
  logic [USER_W-1:0]                  acc_user;
  logic [OUT_DATA_W-1:0]              acc_data_pad;
  logic [OUT_KEEP_W-1:0]              acc_keep_pad;

  logic                  accept;
  logic                  complete;
  logic                  out_valid_q;
  logic [OUT_DATA_W-1:0] out_data_q;
  logic [OUT_KEEP_W-1:0] out_keep_q;
  logic                  out_last_q;
  logic [USER_W-1:0]     out_user_q;
  logic [OUT_DATA_W-1:0] word_data;
  logic [OUT_KEEP_W-1:0] word_keep;
  logic [USER_W-1:0]     word_user;

  assign in_ss.ready = rst && (!out_valid_q || out_ss.ready);
  assign accept      = in_ss.valid && in_ss.ready;
  assign complete    = accept && ((cnt == CNT_W'(RATIO - 1)) || in_ss.last);

  ss_upsizer_acc #(
    .IN_DATA_W (IN_DATA_W),
    .RATIO     (RATIO),
    .USER_W    (USER_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (accept && !complete),
    .clr      (complete),
    .wr_data  (in_ss.data),
    .wr_keep  (in_ss.keep),
    .wr_user  (in_ss.user),
    .cnt      (cnt),
    .acc_data (acc_data),
    .acc_keep (acc_keep),
    .acc_user (acc_user)
  );

  // Pad the accumulator to full width so lane selection below never leaves range.
  assign acc_data_pad = {{IN_DATA_W{1'b0}}, acc_data};
  assign acc_keep_pad = {{IN_KEEP_W{1'b0}}, acc_keep};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    word_data = '0;
    word_keep = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k < int'(cnt)) begin
        word_data[k*IN_DATA_W +: IN_DATA_W] = acc_data_pad[k*IN_DATA_W +: IN_DATA_W];
        word_keep[k*IN_KEEP_W +: IN_KEEP_W] = acc_keep_pad[k*IN_KEEP_W +: IN_KEEP_W];
      end else if (k == int'(cnt)) begin
        word_data[k*IN_DATA_W +: IN_DATA_W] = in_ss.data;
        word_keep[k*IN_KEEP_W +: IN_KEEP_W] = in_ss.keep;
      end
    end
    word_user = (cnt == '0) ? in_ss.user : acc_user;
  end

  // A completing beat reloads even while the old word hands off, so words stream without bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= '0;
    end else if (complete) begin
      out_valid_q <= 1'b1;
      out_data_q  <= word_data;
      out_keep_q  <= word_keep;
      out_last_q  <= in_ss.last;
      out_user_q  <= word_user;
    end else if (out_valid_q && out_ss.ready) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= '0;
    end
  end

  assign out_ss.valid = out_valid_q;
  assign out_ss.data  = out_data_q;
  assign out_ss.keep  = out_keep_q;
  assign out_ss.last  = out_last_q;
  assign out_ss.user  = out_user_q;

`ifdef SS_UPSIZER_ERR_EN
  logic [IN_KEEP_W-1:0] keep_inc;
  logic                 beat_bad;

  // keep is contiguous from lane byte 0 exactly when keep & (keep+1) is zero.
  assign keep_inc = in_ss.keep + IN_KEEP_W'(1);
  assign beat_bad = (!in_ss.last && !(&in_ss.keep)) || ((in_ss.keep & keep_inc) != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (accept && beat_bad) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ss_upsizer.sv
// Directed self-checking bench for ss_upsizer (IN_DATA_W=32, RATIO=4) with a word-level scoreboard.
module tb_ss_upsizer;
  import ss_pkg::*;

  localparam int IN_W  = 32;
  localparam int RATIO = 4;
  localparam int OUT_W = IN_W * RATIO;
  localparam int OKW   = OUT_W / 8;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [OKW-1:0]   keep;
    logic             last;
    logic [0:0]       user;
  } word_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   wait_cycles;

  ss_upsizer_if #(.DATA_W(IN_W),  .USER_W(1)) in_ss ();
  ss_upsizer_if #(.DATA_W(OUT_W), .USER_W(1)) out_ss ();
`ifdef SS_UPSIZER_ERR_EN
  logic err;
`endif

  ss_upsizer #(.IN_DATA_W(IN_W), .RATIO(RATIO), .USER_W(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .in_ss  (in_ss),
    .out_ss (out_ss)
`ifdef SS_UPSIZER_ERR_EN
    ,
    .err    (err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard model: gathers accepted beats into words from the packing rules.
  word_t            exp_q[$];
  logic [OUT_W-1:0] m_data;
  logic [OKW-1:0]   m_keep;
  logic [0:0]       m_user;
  int               m_n;
  logic             m_err;

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_in_ready", in_ss.ready, 0);
      check("rst_out_valid", out_ss.valid, 0);
      exp_q.delete();
      m_n    = 0;
      m_data = '0;
      m_keep = '0;
      m_err  = 1'b0;
    end else begin
      check("in_ready", in_ss.ready, !out_ss.valid || out_ss.ready);
      check("out_valid", out_ss.valid, exp_q.size() != 0);
`ifdef SS_UPSIZER_ERR_EN
      check("err", err, m_err);
`endif
      if (out_ss.valid && exp_q.size() != 0) begin
        check("out_data", out_ss.data, exp_q[0].data);
        check("out_keep", out_ss.keep, exp_q[0].keep);
        check("out_last", out_ss.last, exp_q[0].last);
        check("out_user", out_ss.user, exp_q[0].user);
        if (out_ss.ready) void'(exp_q.pop_front());
      end
      if (in_ss.valid && in_ss.ready) begin
        if (!in_ss.last && in_ss.keep != 4'hF) m_err = 1'b1;
        if (in_ss.keep inside {4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE})
          m_err = 1'b1;
        if (m_n == 0) m_user = in_ss.user;
        m_data[m_n*IN_W +: IN_W] = in_ss.data;
        m_keep[m_n*4 +: 4]       = in_ss.keep;
        m_n++;
        if (m_n == RATIO || in_ss.last) begin
          exp_q.push_back('{data: m_data, keep: m_keep, last: in_ss.last, user: m_user});
          m_n    = 0;
          m_data = '0;
          m_keep = '0;
        end
      end
    end
  end

  task automatic send(input ss_beat_t b);
    int n;
    n = 0;
    in_ss.valid = 1'b1;
    in_ss.data  = b.data;
    in_ss.keep  = b.keep;
    in_ss.last  = b.last;
    in_ss.user  = b.user;
    @(negedge clk);
    while (!in_ss.ready && n < 50) begin
      n++;
      wait_cycles++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=no_accept required=accept_within_50");
    end
    @(posedge clk);
    #1;
    in_ss.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  ss_beat_t t1[4] = '{'{32'h11111111, 4'hF, 1'b0, 1'b1}, '{32'h22222222, 4'hF, 1'b0, 1'b0},
                      '{32'h33333333, 4'hF, 1'b0, 1'b0}, '{32'h44444444, 4'hF, 1'b1, 1'b0}};
  ss_beat_t t2[2] = '{'{32'hA0A0A0A0, 4'hF, 1'b0, 1'b0}, '{32'hB0B0B0B0, 4'h3, 1'b1, 1'b1}};
  ss_beat_t t5[4] = '{'{32'hC0000001, 4'hF, 1'b0, 1'b1}, '{32'hC0000002, 4'hF, 1'b0, 1'b1},
                      '{32'hC0000003, 4'hF, 1'b0, 1'b0}, '{32'hC0000004, 4'hF, 1'b1, 1'b0}};

  initial begin
    checks      = 0;
    failures    = 0;
    wait_cycles = 0;
    rst          = 1'b0;
    in_ss.valid  = 1'b0;
    in_ss.data   = '0;
    in_ss.keep   = '0;
    in_ss.last   = 1'b0;
    in_ss.user   = '0;
    out_ss.ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_data", out_ss.data, 0);
    check("reset_out_keep", out_ss.keep, 0);
    check("reset_out_last", out_ss.last, 0);
    check("reset_out_user", out_ss.user, 0);
`ifdef SS_UPSIZER_ERR_EN
    check("reset_err", err, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    // Full 4-beat packet: word appears one cycle after beat 4.
    foreach (t1[i]) send(t1[i]);
    @(negedge clk);
    check("t1_valid", out_ss.valid, 1);
    check("t1_data", out_ss.data, 128'h44444444_33333333_22222222_11111111);
    check("t1_keep", out_ss.keep, 16'hFFFF);
    check("t1_last", out_ss.last, 1);
    check("t1_user", out_ss.user, 1);
    idle(3);

    // Short packet flushes early with upper lanes zeroed.
    foreach (t2[i]) send(t2[i]);
    @(negedge clk);
    check("t2_valid", out_ss.valid, 1);
    check("t2_data", out_ss.data, 128'h00000000_00000000_B0B0B0B0_A0A0A0A0);
    check("t2_keep", out_ss.keep, 16'h003F);
    check("t2_last", out_ss.last, 1);
    check("t2_user", out_ss.user, 0);
    idle(3);

    // Eight beats with a 3-cycle downstream stall when the first word appears.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send('{32'h50000001 + i, 4'hF, i == 7, 1'(i)});
      end
      begin
        int n;
        n = 0;
        while (!out_ss.valid && n < 100) begin
          @(posedge clk);
          #1;
          n++;
        end
        check("stall_word_seen", n < 100, 1);
        out_ss.ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", in_ss.ready, 0);
          check("stall_hold_data", out_ss.data, 128'h50000004_50000003_50000002_50000001);
        end
        @(posedge clk);
        #1 out_ready_restore();
      end
    join
    idle(4);

    // Continuous stream: never a wait cycle on the input side.
    wait_cycles = 0;
    for (int i = 0; i < 8; i++)
      send('{32'h60000000 + i, 4'hF, i == 7, 1'b0});
    check("stream_no_bubble", wait_cycles, 0);
    idle(3);

    // Reset in the middle of a word discards the partial beats.
    send('{32'hDEAD0001, 4'hF, 1'b0, 1'b0});
    send('{32'hDEAD0002, 4'hF, 1'b0, 1'b0});
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_ss.valid, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(1);
    foreach (t5[i]) send(t5[i]);
    @(negedge clk);
    check("t5_data", out_ss.data, 128'hC0000004_C0000003_C0000002_C0000001);
    check("t5_keep", out_ss.keep, 16'hFFFF);
    check("t5_user", out_ss.user, 1);
    idle(3);

`ifdef SS_UPSIZER_ERR_EN
    // Partial keep on a non-last beat sets err, which holds until reset.
    check("err_before", err, 0);
    send('{32'h70000001, 4'h7, 1'b0, 1'b0});
    @(negedge clk);
    check("err_set", err, 1);
    for (int i = 1; i < 4; i++)
      send('{32'h70000001 + i, 4'hF, i == 3, 1'b0});
    idle(2);
    @(negedge clk);
    check("err_sticky", err, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("err_cleared", err, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle(2);
`endif

    @(negedge clk);
    check("drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic out_ready_restore();
    out_ss.ready = 1'b1;
  endtask

endmodule
